// File: rtl/e203_dtcm_icb2sram.sv
// DTCM ICB-to-SRAM bridge: ICB command -> single-port SRAM strobes, 1-cycle read
// data captured into an in-order response FIFO, idle-timeout light-sleep control.
module e203_dtcm_icb2sram #(
  parameter int ADDR_W      = 16,
  parameter int RAM_AW      = 14,
  parameter int DW          = 32,
  parameter int MW          = 4,
  parameter int RSP_DEPTH   = 2,
  parameter int IDLE_LS_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lp_en,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [MW-1:0]     icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_ls,
  output logic              ram_ds,
  output logic              ram_sd
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam int NW = $clog2(RSP_DEPTH + 2);
  localparam int CW = $clog2(IDLE_LS_CYC);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_LS_CYC - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_LS, ST_WAKE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   idle_cnt, idle_nxt;
  logic            oor, cmd_fire, rsp_fire, idle;
  logic            inflight, inflight_rd, inflight_oor;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   count;
  logic [NW-1:0]   cnt;
  logic [DW-1:0]   push_rdata;
  logic [DW-1:0]   mem_rdata [RSP_DEPTH];
  logic            mem_err   [RSP_DEPTH];
  logic            unused_addr_lsb;

  // Address bits above the SRAM window only exist when ADDR_W is wider than it
  generate
    if (ADDR_W > RAM_AW + 2) begin : g_oor
      assign oor = |icb_cmd_addr[ADDR_W-1:RAM_AW+2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign unused_addr_lsb = ^icb_cmd_addr[1:0];

  assign cnt           = NW'(count) + NW'(inflight);
  assign icb_rsp_valid = (count != '0);
  assign rsp_fire      = icb_rsp_valid & icb_rsp_ready;
  assign icb_cmd_ready = ~rst & (state == ST_ACTIVE) & ((cnt < NW'(RSP_DEPTH)) | rsp_fire);
  assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;

  assign ram_cs   = cmd_fire & ~oor;
  assign ram_we   = ~icb_cmd_read;
  assign ram_addr = icb_cmd_addr[RAM_AW+1:2];
  assign ram_wem  = icb_cmd_wmask;
  assign ram_din  = icb_cmd_wdata;
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  assign icb_rsp_rdata = mem_rdata[rd_ptr];
  assign icb_rsp_err   = mem_err[rd_ptr];
  assign push_rdata    = (inflight_rd & ~inflight_oor) ? ram_dout : '0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_rd  <= 1'b0;
      inflight_oor <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      inflight     <= cmd_fire;
      inflight_rd  <= icb_cmd_read;
      inflight_oor <= oor;
      if (inflight) wr_ptr <= ptr_inc(wr_ptr);
      if (rsp_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({inflight, rsp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) begin
      mem_rdata[wr_ptr] <= push_rdata;
      mem_err[wr_ptr]   <= inflight_oor;
    end
  end

  assign idle = ~icb_cmd_valid & (cnt == '0);

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    case (state)
      ST_ACTIVE: begin
        if (!idle)                 idle_nxt = '0;
        else if (idle_cnt != IDLE_MAX) idle_nxt = idle_cnt + 1'b1;
        // Require idle on the decision cycle so a command can never fire into LS
        if (lp_en && idle && (idle_cnt == IDLE_MAX)) state_nxt = ST_LS;
      end
      ST_LS: begin
        if (icb_cmd_valid || !lp_en) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        state_nxt = ST_ACTIVE;
        idle_nxt  = '0;
      end
      default: begin
        state_nxt = ST_ACTIVE;
        idle_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      ram_ls   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      ram_ls   <= (state_nxt == ST_LS);
    end
  end

endmodule

// File: tb/tb_e203_dtcm_icb2sram.sv
// Directed bench for e203_dtcm_icb2sram with a behavioural 1-cycle SRAM model.
module tb_e203_dtcm_icb2sram;

  logic        clk = 1'b0;
  logic        rst, lp_en;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [16:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_dtcm_icb2sram #(
    .ADDR_W(17), .RAM_AW(14), .DW(32), .MW(4), .RSP_DEPTH(2), .IDLE_LS_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .lp_en(lp_en),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  // SRAM model: unwritten words read back as {16'hC0DE, word address}
  logic [31:0] mem [16384];
  bit          mem_wr [16384];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        if (!mem_wr[ram_addr] && ram_wem != 4'hF) begin
          for (int b = 0; b < 4; b++)
            if (!ram_wem[b]) mem[ram_addr][b*8 +: 8] <= {16'hC0DE, 2'b00, ram_addr} >> (b*8);
        end
        mem_wr[ram_addr] <= 1'b1;
      end else begin
        ram_dout <= mem_wr[ram_addr] ? mem[ram_addr] : {16'hC0DE, 2'b00, ram_addr};
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [16:0] a, input logic [31:0] wd, input logic [3:0] wm);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; lp_en = 1'b0; icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_rsp_valid", 64'(icb_rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(icb_cmd_ready), 64'd0);
    chk("rst_ram_ls",    64'(ram_ls),        64'd0);
    chk("ram_ds_sd",     64'({ram_ds, ram_sd}), 64'd0);
    rst = 1'b0;

    // Single write then read
    cyc(); drive(1'b0, 17'h0010, 32'hDEADBEEF, 4'hF); #1;
    chk("wr_ready", 64'(icb_cmd_ready), 64'd1);
    chk("wr_cs_we", 64'({ram_cs, ram_we}), 64'd3);
    chk("wr_addr",  64'(ram_addr), 64'd4);
    chk("wr_din",   64'({ram_wem, ram_din}), 64'hF_DEADBEEF);
    cyc(); icb_cmd_valid = 1'b0; #1;
    chk("wr_inflight_novalid", 64'(icb_rsp_valid), 64'd0);
    cyc(); #1;
    chk("wr_rsp", 64'({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}), {31'd0, 1'b1, 1'b0, 32'h0});
    cyc(); drive(1'b1, 17'h0010, 32'h0, 4'h0); #1;
    chk("rd_cs_we", 64'({ram_cs, ram_we}), 64'd2);
    chk("rd_addr",  64'(ram_addr), 64'd4);
    cyc(); icb_cmd_valid = 1'b0; #1;
    chk("rd_inflight_novalid", 64'(icb_rsp_valid), 64'd0);
    cyc(); #1;
    chk("rd_rsp", 64'({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}), {31'd0, 1'b1, 1'b0, 32'hDEADBEEF});
    cyc(); #1;
    chk("rd_drained", 64'(icb_rsp_valid), 64'd0);

    // Byte mask
    cyc(); drive(1'b0, 17'h0020, 32'h11223344, 4'hF);
    cyc(); drive(1'b0, 17'h0020, 32'hAA000000, 4'h8); #1;
    chk("bm_wem", 64'({ram_cs, ram_wem}), 64'h18);
    cyc(); drive(1'b1, 17'h0020, 32'h0, 4'h0); #1;
    chk("bm_rd_ready", 64'(icb_cmd_ready), 64'd1);
    cyc(); icb_cmd_valid = 1'b0; #1;
    chk("bm_rsp_w2", 64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'h0});
    cyc(); #1;
    chk("bm_rsp_rd", 64'({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}), {31'd0, 1'b1, 1'b0, 32'hAA223344});
    cyc(); #1;
    chk("bm_drained", 64'(icb_rsp_valid), 64'd0);

    // Back-to-back reads, full throughput
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k < 8) drive(1'b1, 17'(32'h100 + 4 * k), 32'h0, 4'h0);
      else icb_cmd_valid = 1'b0;
      #1;
      if (k < 8) chk("b2b_ready", 64'(icb_cmd_ready), 64'd1);
      if (k >= 2) chk("b2b_rsp", 64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'hC0DE0040 + 32'(k - 2)});
      else chk("b2b_early", 64'(icb_rsp_valid), 64'd0);
    end
    cyc(); #1;
    chk("b2b_drained", 64'(icb_rsp_valid), 64'd0);

    // Backpressure: only RSP_DEPTH credits
    icb_rsp_ready = 1'b0;
    cyc(); drive(1'b1, 17'h0200, 32'h0, 4'h0); #1;
    chk("bp_ready0", 64'(icb_cmd_ready), 64'd1);
    cyc(); drive(1'b1, 17'h0204, 32'h0, 4'h0); #1;
    chk("bp_ready1", 64'(icb_cmd_ready), 64'd1);
    cyc(); drive(1'b1, 17'h0208, 32'h0, 4'h0); #1;
    chk("bp_stall2", 64'(icb_cmd_ready), 64'd0);
    cyc(); #1;
    chk("bp_stall3", 64'(icb_cmd_ready), 64'd0);
    chk("bp_head",   64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'hC0DE0080});
    cyc(); #1;
    chk("bp_hold",   64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'hC0DE0080});
    icb_rsp_ready = 1'b1; #1;
    chk("bp_ready_on_pop", 64'(icb_cmd_ready), 64'd1);
    cyc(); drive(1'b1, 17'h020C, 32'h0, 4'h0); #1;
    chk("bp_ready_full_pop", 64'(icb_cmd_ready), 64'd1);
    chk("bp_rsp1", 64'(icb_rsp_rdata), 64'hC0DE0081);
    cyc(); icb_cmd_valid = 1'b0; #1;
    chk("bp_rsp2", 64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'hC0DE0082});
    cyc(); #1;
    chk("bp_rsp3", 64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'hC0DE0083});
    cyc(); #1;
    chk("bp_drained", 64'(icb_rsp_valid), 64'd0);

    // Out of range
    cyc(); drive(1'b1, 17'h10000, 32'h0, 4'h0); #1;
    chk("oor_ready", 64'(icb_cmd_ready), 64'd1);
    chk("oor_no_cs", 64'(ram_cs), 64'd0);
    cyc(); icb_cmd_valid = 1'b0;
    cyc(); #1;
    chk("oor_rsp", 64'({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}), {31'd0, 1'b1, 1'b1, 32'h0});
    cyc(); #1;
    chk("oor_drained", 64'(icb_rsp_valid), 64'd0);

    // Light sleep entry after 16 idle cycles
    rst = 1'b1; lp_en = 1'b1;
    cyc(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin #1; chk("ls_not_yet", 64'(ram_ls), 64'd0); end
      cyc();
    end
    #1;
    chk("ls_entered", 64'({ram_ls, icb_cmd_ready}), 64'b10);
    drive(1'b1, 17'h0010, 32'h0, 4'h0); #1;
    chk("ls_blocked", 64'({ram_ls, icb_cmd_ready, ram_cs}), 64'b100);
    cyc(); #1;
    chk("wake", 64'({ram_ls, icb_cmd_ready, ram_cs}), 64'b000);
    cyc(); #1;
    chk("wake_accept", 64'({ram_ls, icb_cmd_ready, ram_cs}), 64'b011);
    cyc(); icb_cmd_valid = 1'b0;
    cyc(); #1;
    chk("wake_rsp", 64'({icb_rsp_valid, icb_rsp_rdata}), {31'd0, 1'b1, 32'hDEADBEEF});
    repeat (25) cyc();
    #1;
    chk("ls_reentered", 64'(ram_ls), 64'd1);
    rst = 1'b1;
    cyc(); #1;
    chk("ls_rst", 64'({ram_ls, icb_cmd_ready}), 64'b00);
    rst = 1'b0;
    cyc(); #1;
    chk("post_rst_active", 64'({ram_ls, icb_cmd_ready}), 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
